// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
// Holds the fetch FSM state encoding, the NOP instruction and the default reset PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK          = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {inst, pc} buffer that parks a fetched instruction while IF/ID is stalled.
// Clear beats capture, and capture beats consume.
module fetch_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_capture,
  input  logic        i_consume,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic        o_full,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  logic        full_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      inst_q <= NOP_INST;
      pc_q   <= '0;
    end else if (i_clear) begin
      full_q <= 1'b0;
    end else if (i_capture) begin
      full_q <= 1'b1;
      inst_q <= i_inst;
      pc_q   <= i_pc;
    end else if (i_consume) begin
      full_q <= 1'b0;
    end
  end

  assign o_full = full_q;
  assign o_inst = inst_q;
  assign o_pc   = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem requests, IF/ID register.
// Define FETCH_PERF_EN to add the fetched/dropped response counters.
//
// state  | meaning
// S_BOOT | first cycle after reset, raises o_rst_stall, no request
// S_REQ  | presenting pc_q to imem until accepted
// S_WAIT | request accepted, waiting for its response
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall_pc,
  input  logic        i_stall_if_id,
  input  logic        i_flush,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_ren,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_id_inst,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc4,
  output logic        o_if_id_valid,
  output logic        o_rst_stall
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_dropped
`endif
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] inflight_pc_q;
  logic        drop_q;
  logic        ren;

  logic        hold_full;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;

  logic flush_eff;
  logic accept;
  logic resp;
  logic deliver;
  logic discard;

  // A redirect during boot has nothing to cancel and is ignored.
  assign flush_eff = i_flush && (state_q != S_BOOT);
  assign accept    = ren && i_imem_ready;
  assign resp      = (state_q == S_WAIT) && i_imem_valid;
  assign deliver   = resp && !drop_q && !i_flush;
  assign discard   = resp && (drop_q || i_flush);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ren         = 1'b0;
    o_rst_stall = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        o_rst_stall = 1'b1;
        state_d     = S_REQ;
      end
      S_REQ: begin
        ren = !i_flush && !i_stall_pc && !hold_full;
        if (ren && i_imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_valid) state_d = S_REQ;
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign o_imem_ren  = ren;
  assign o_imem_addr = pc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= word_align(RESET_ADDR);
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      if (flush_eff)   pc_q <= word_align(i_redirect_pc);
      else if (accept) pc_q <= pc_q + 32'd4;
      if (accept) inflight_pc_q <= pc_q;
      // The response in flight at redirect time belongs to the old path.
      if (resp)                                   drop_q <= 1'b0;
      else if (flush_eff && (state_q == S_WAIT)) drop_q <= 1'b1;
    end
  end

  fetch_hold_buf u_hold_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_capture (deliver && i_stall_if_id),
    .i_consume (!flush_eff && !i_stall_if_id && hold_full),
    .i_clear   (flush_eff),
    .i_inst    (i_imem_rdata),
    .i_pc      (inflight_pc_q),
    .o_full    (hold_full),
    .o_inst    (hold_inst),
    .o_pc      (hold_pc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_if_id_inst  <= NOP_INST;
      o_if_id_pc    <= '0;
      o_if_id_pc4   <= '0;
      o_if_id_valid <= 1'b0;
    end else if (flush_eff) begin
      o_if_id_inst  <= NOP_INST;
      o_if_id_pc    <= '0;
      o_if_id_pc4   <= '0;
      o_if_id_valid <= 1'b0;
    end else if (!i_stall_if_id) begin
      if (hold_full) begin
        o_if_id_inst  <= hold_inst;
        o_if_id_pc    <= hold_pc;
        o_if_id_pc4   <= hold_pc + 32'd4;
        o_if_id_valid <= 1'b1;
      end else if (deliver) begin
        o_if_id_inst  <= i_imem_rdata;
        o_if_id_pc    <= inflight_pc_q;
        o_if_id_pc4   <= inflight_pc_q + 32'd4;
        o_if_id_valid <= 1'b1;
      end else begin
        o_if_id_inst  <= NOP_INST;
        o_if_id_pc    <= '0;
        o_if_id_pc4   <= '0;
        o_if_id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_dropped_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (deliver) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (discard) perf_dropped_q <= perf_dropped_q + 32'd1;
    end
  end

  assign o_perf_fetched = perf_fetched_q;
  assign o_perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level fetch model.
// Honors FETCH_PERF_EN for the optional counter ports.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_ADDR = 32'h0000_0100;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stall_pc = 1'b0;
  logic        i_stall_if_id = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_ren;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready = 1'b0;
  logic        i_imem_valid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic [31:0] o_if_id_inst;
  logic [31:0] o_if_id_pc;
  logic [31:0] o_if_id_pc4;
  logic        o_if_id_valid;
  logic        o_rst_stall;
`ifdef FETCH_PERF_EN
  logic [31:0] o_perf_fetched;
  logic [31:0] o_perf_dropped;
`endif

  fetch_unit #(.RESET_ADDR(RST_ADDR)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_stall_pc    (i_stall_pc),
    .i_stall_if_id (i_stall_if_id),
    .i_flush       (i_flush),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_ren    (o_imem_ren),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_valid  (i_imem_valid),
    .i_imem_rdata  (i_imem_rdata),
    .o_if_id_inst  (o_if_id_inst),
    .o_if_id_pc    (o_if_id_pc),
    .o_if_id_pc4   (o_if_id_pc4),
    .o_if_id_valid (o_if_id_valid),
    .o_rst_stall   (o_rst_stall)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetched(o_perf_fetched),
    .o_perf_dropped(o_perf_dropped)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_t;

  // model: next fetch PC, the one outstanding request, instructions waiting behind a stalled IF/ID
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_out;
  bit          m_killed;
  logic [31:0] m_inflight;
  fetch_t      m_pend[$];
  bit          m_ifv;
  logic [31:0] m_ifinst;
  logic [31:0] m_ifpc;
  logic [31:0] m_fetched;
  logic [31:0] m_dropped;
  int          m_lat;

  int  p_stall_pc, p_stall_ifid, p_flush, p_nrdy, max_lat, p_stray;
  bit  force_flush = 0;
  logic [31:0] force_target;

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return {addr[15:0] ^ 16'h5A3C, addr[31:16]} + 32'h0001_3579;
  endfunction

  task automatic model_reset();
    m_pc = RST_ADDR; m_boot = 1; m_out = 0; m_killed = 0; m_inflight = '0;
    m_pend.delete(); m_ifv = 0; m_ifinst = NOP_INST; m_ifpc = '0;
    m_fetched = '0; m_dropped = '0; m_lat = 0;
  endtask

  task automatic set_knobs(input int sp, input int si, input int fl, input int nr, input int ml, input int st);
    p_stall_pc = sp; p_stall_ifid = si; p_flush = fl; p_nrdy = nr; max_lat = ml; p_stray = st;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    bit exp_ren, flush_eff, accept, resp, deliver;
    fetch_t r;
    chk("rst_stall", o_rst_stall, m_boot);
    chk("if_id_valid", o_if_id_valid, m_ifv);
    if (m_ifv) begin
      chk("if_id_inst", o_if_id_inst, m_ifinst);
      chk("if_id_pc", o_if_id_pc, m_ifpc);
      chk("if_id_pc4", o_if_id_pc4, m_ifpc + 32'd4);
    end else begin
      chk("bubble_inst", o_if_id_inst, NOP_INST);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", o_perf_fetched, m_fetched);
    chk("perf_dropped", o_perf_dropped, m_dropped);
`endif
    i_stall_pc    = ($urandom_range(0, 99) < p_stall_pc);
    i_stall_if_id = ($urandom_range(0, 99) < p_stall_ifid);
    if (force_flush) begin
      i_flush = 1'b1; i_redirect_pc = force_target; force_flush = 0;
    end else begin
      i_flush = ($urandom_range(0, 99) < p_flush); i_redirect_pc = $urandom;
    end
    i_imem_ready = !($urandom_range(0, 99) < p_nrdy);
    if (m_out) begin
      if (m_lat == 0) begin
        i_imem_valid = 1'b1; i_imem_rdata = inst_of(m_inflight);
      end else begin
        m_lat--; i_imem_valid = 1'b0; i_imem_rdata = $urandom;
      end
    end else begin
      i_imem_valid = ($urandom_range(0, 99) < p_stray); i_imem_rdata = $urandom;
    end
    #1;
    exp_ren = !m_boot && !m_out && !i_flush && !i_stall_pc && (m_pend.size() == 0);
    chk("imem_ren", o_imem_ren, exp_ren);
    if (exp_ren) chk("imem_addr", o_imem_addr, m_pc);

    flush_eff = i_flush && !m_boot;
    accept    = exp_ren && i_imem_ready;
    resp      = m_out && i_imem_valid;
    deliver   = resp && !m_killed && !i_flush;
    if (deliver) m_fetched++;
    if (resp && !deliver) m_dropped++;
    if (flush_eff) begin
      m_ifv = 0; m_pend.delete();
    end else if (!i_stall_if_id) begin
      if (m_pend.size() != 0) begin
        r = m_pend.pop_front(); m_ifv = 1; m_ifinst = r.inst; m_ifpc = r.pc;
      end else if (deliver) begin
        m_ifv = 1; m_ifinst = inst_of(m_inflight); m_ifpc = m_inflight;
      end else begin
        m_ifv = 0;
      end
    end else if (deliver) begin
      m_pend.push_back('{inst: inst_of(m_inflight), pc: m_inflight});
    end
    if (resp) m_out = 0;
    else if (flush_eff && m_out) m_killed = 1;
    if (accept) begin
      m_out = 1; m_killed = 0; m_inflight = m_pc; m_lat = $urandom_range(0, max_lat);
    end
    if (flush_eff)   m_pc = i_redirect_pc & 32'hFFFF_FFFC;
    else if (accept) m_pc = m_pc + 32'd4;
    m_boot = 0;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_imem_valid = 1'b0; i_flush = 1'b0; i_stall_pc = 1'b0; i_stall_if_id = 1'b0;
    model_reset();
    #1;
    chk("rst_ren", o_imem_ren, 1'b0);
    chk("rst_addr", o_imem_addr, RST_ADDR);
    chk("rst_stall_async", o_rst_stall, 1'b1);
    chk("rst_valid", o_if_id_valid, 1'b0);
    chk("rst_inst", o_if_id_inst, NOP_INST);
    chk("rst_pc", o_if_id_pc, 32'h0);
    chk("rst_pc4", o_if_id_pc4, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", o_perf_fetched, 32'h0);
    chk("rst_perf_dropped", o_perf_dropped, 32'h0);
`endif
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b1;
    #2;
    do_reset();

    // zero-wait, no stalls: back-to-back fetch from the reset address
    set_knobs(0, 0, 0, 0, 0, 0);
    repeat (8) step();

    // memory not ready for three cycles
    for (int k = 0; k < 10 && m_out; k++) step();
    set_knobs(0, 0, 0, 100, 0, 0);
    repeat (3) step();
    set_knobs(0, 0, 0, 0, 0, 0);
    repeat (4) step();

    // redirect while waiting on a response
    for (int k = 0; k < 10 && !m_out; k++) step();
    force_flush = 1; force_target = 32'h0000_0200;
    repeat (6) step();

    // IF/ID stalled across a response
    set_knobs(0, 100, 0, 0, 0, 0);
    repeat (4) step();
    set_knobs(0, 0, 0, 0, 0, 0);
    repeat (4) step();

    // PC stall, then wrap past the top of the address space
    set_knobs(100, 0, 0, 0, 0, 0);
    repeat (3) step();
    set_knobs(0, 0, 0, 0, 0, 0);
    force_flush = 1; force_target = 32'hFFFF_FFFA;
    repeat (8) step();

    set_knobs(15, 20, 8, 30, 3, 10);
    repeat (3000) step();

    // reset in the middle of an outstanding request
    for (int k = 0; k < 50 && !m_out; k++) step();
    do_reset();
    set_knobs(15, 20, 8, 30, 3, 25);
    repeat (1500) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC, issues requests to instruction memory, and loads the IF/ID pipeline register consumed by decode. It obeys the PC/IF-ID stall controls from hazard detection and the taken-branch/JALR redirect from ID. It drops responses made stale by a redirect and produces the post-reset stall pulse that hazard detection turns into a bubble.

## Interface
- RESET_ADDR, 32'h0000_0000, PC value after reset (bits [1:0] must be 00)
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_stall_pc  in  1  hold PC and suppress new request
- i_stall_if_id  in  1  hold IF/ID register contents
- i_flush  in  1  redirect taken (branch/JALR resolved in ID)
- i_redirect_pc  in  32  redirect target; bits [1:0] ignored
- o_imem_ren  out  1  request valid
- o_imem_addr  out  32  request address, bits [1:0] always 00
- i_imem_ready  in  1  memory accepts request this cycle
- i_imem_valid  in  1  response valid, in order, ≥1 cycle after accept
- i_imem_rdata  in  32  response instruction
- o_if_id_inst  out  32  IF/ID instruction
- o_if_id_pc  out  32  IF/ID PC
- o_if_id_pc4  out  32  IF/ID PC+4
- o_if_id_valid  out  1  IF/ID holds a real instruction
- o_rst_stall  out  1  post-reset stall pulse to hazard detection

## Operation
- Single outstanding request. FSM states: S_BOOT, S_REQ, S_WAIT.
- S_BOOT (reset state): o_rst_stall=1, o_imem_ren=0. Unconditionally moves to S_REQ on the next edge.
- S_REQ: o_imem_ren = !i_flush & !i_stall_pc & !hold_full. o_imem_addr = pc_q.
  - On accept (ren & ready): inflight_pc <= pc_q; pc_q <= pc_q+4; go to S_WAIT.
- S_WAIT: o_imem_ren=0. On i_imem_valid, go to S_REQ and do one of:
  - drop flag set: discard response and clear the flag.
  - otherwise: deliver {rdata, inflight_pc}.
- Flush (any state except S_BOOT): pc_q <= {i_redirect_pc[31:2],2'b00}; hold buffer cleared.
  - Flush in S_WAIT without a same-cycle response: set drop flag.
  - Flush with a same-cycle response: discard that response; drop flag not set.
  - Flush has priority over both stalls.
- Delivery:
  - If !i_stall_if_id, write IF/ID directly with inst, pc, pc+4, valid=1.
  - Else capture into the one-entry hold buffer (hold_full=1).
  - Each unstalled cycle, IF/ID load priority: flush → bubble (valid=0, inst=NOP 32'h0000_0013); hold buffer (then clear it); direct response; else bubble.
- i_stall_if_id=1 and no flush: IF/ID unchanged.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset values: pc_q=RESET_ADDR, state S_BOOT, o_rst_stall=1, o_imem_ren=0, o_imem_addr=RESET_ADDR, IF/ID valid=0 / inst=NOP / pc=0 / pc4=0, hold_full=0, drop=0.
- Cycle 0 after reset release: S_BOOT. First request in cycle 1.
- Zero-wait memory (ready=1, valid the cycle after accept): one instruction every 2 cycles. Response at edge N appears on IF/ID outputs after edge N.
- o_imem_addr is stable while o_imem_ren=1 and ready=0.
- Reset asserted mid-request: all state returns to reset values immediately. A later stray i_imem_valid while in S_BOOT/S_REQ is ignored.
- i_imem_valid outside S_WAIT is ignored.

## Configuration
- FETCH_PERF_EN defined:
  - Adds o_perf_fetched (32, out), counting delivered responses.
  - Adds o_perf_dropped (32, out), counting discarded responses.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared pipeline package: FSM state enum, NOP_INST=32'h0000_0013, default RESET_ADDR.
- Sub-module fetch_hold_buf: one-entry {inst, pc} register with capture/consume/clear, exposing hold_full.

## Test plan
- Reset release, RESET_ADDR=0x100, zero-wait memory → o_rst_stall high through cycle 0; requests to 0x100, 0x104, 0x108; IF/ID pc sequence 0x100, 0x104, 0x108 with valid=1.
- ready held low 3 cycles at 0x104 → o_imem_addr stays 0x104; no PC advance; accepted in cycle 4.
- Flush to 0x200 while in S_WAIT for 0x108 → 0x108 response discarded (perf_dropped=1 with FETCH_PERF_EN); IF/ID bubble; next request 0x200.
- Response arrives with i_stall_if_id=1 for 2 cycles → captured in hold buffer; no new request; IF/ID loads it on the first unstalled cycle.
- i_stall_pc=1 in S_REQ → o_imem_ren=0 and pc_q held; ren resumes the cycle after release.
- pc_q=0xFFFF_FFFC accepted → next request address 0x0000_0000.
